// File: rtl/despachador_pkg.sv
// despachador_pkg: shared field layout defaults, control indices, error codes and FSM encoding
package despachador_pkg;
  localparam int BITS_MEMORY_DATA_DEF = 32;
  localparam int BITS_ADDR_MEM_ONCHIP_DEF = 14;
  localparam int BITS_BUS_DATOS_INSTR_DEF = 24;
  localparam int BITS_TARGET_DEF = 3;
  localparam int NUM_TARGETS_DEF = 2;
  localparam int MAX_INSTR_DEF = 4096;
  localparam int IDX_END = 0;
  localparam int IDX_SYNC = 1;
  typedef enum logic [1:0] {ERR_NINGUNO = 2'd0, ERR_TARGET = 2'd1, ERR_LIMITE = 2'd2} error_t;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_SYNC, S_DRAIN} estado_t;
  typedef enum logic [2:0] {CL_WRITE, CL_END, CL_SYNC, CL_NOP, CL_BAD} clase_t;
endpackage

// File: rtl/despachador_instrucciones_if.sv
// despachador_instrucciones_if: instruction memory read port plus register-write bus
interface despachador_instrucciones_if
  import despachador_pkg::*;
#(
  parameter int BITS_MEMORY_DATA = BITS_MEMORY_DATA_DEF,
  parameter int BITS_ADDR_MEM_ONCHIP = BITS_ADDR_MEM_ONCHIP_DEF,
  parameter int BITS_BUS_DATOS_INSTR = BITS_BUS_DATOS_INSTR_DEF,
  parameter int BITS_TARGET = BITS_TARGET_DEF,
  parameter int NUM_TARGETS = NUM_TARGETS_DEF
);
  localparam int BITS_REG_INDEX = BITS_MEMORY_DATA - BITS_BUS_DATOS_INSTR - BITS_TARGET;
  logic read_mem;
  logic [BITS_ADDR_MEM_ONCHIP-1:0] address_mem;
  logic op_complete_mem;
  logic [BITS_MEMORY_DATA-1:0] data_mem;
  logic [NUM_TARGETS-1:0] target_ocupado;
  logic [NUM_TARGETS-1:0] reg_wr_en;
  logic [BITS_REG_INDEX-1:0] reg_addr;
  logic [BITS_BUS_DATOS_INSTR-1:0] reg_data;
  modport master (
    output read_mem, address_mem, reg_wr_en, reg_addr, reg_data,
    input op_complete_mem, data_mem, target_ocupado
  );
  modport slave (
    input read_mem, address_mem, reg_wr_en, reg_addr, reg_data,
    output op_complete_mem, data_mem, target_ocupado
  );
endinterface

// File: rtl/decodificador_instruccion.sv
// decodificador_instruccion: splits an instruction word into fields and classifies it
module decodificador_instruccion
  import despachador_pkg::*;
#(
  parameter int BITS_MEMORY_DATA = BITS_MEMORY_DATA_DEF,
  parameter int BITS_BUS_DATOS_INSTR = BITS_BUS_DATOS_INSTR_DEF,
  parameter int BITS_TARGET = BITS_TARGET_DEF,
  parameter int NUM_TARGETS = NUM_TARGETS_DEF,
  localparam int BITS_REG_INDEX = BITS_MEMORY_DATA - BITS_BUS_DATOS_INSTR - BITS_TARGET
) (
  input logic [BITS_MEMORY_DATA-1:0] instr,
  output clase_t clase,
  output logic [NUM_TARGETS-1:0] sel,
  output logic [BITS_REG_INDEX-1:0] indice,
  output logic [BITS_BUS_DATOS_INSTR-1:0] dato
);
  logic [BITS_TARGET-1:0] target;
  assign target = instr[BITS_MEMORY_DATA-1 -: BITS_TARGET];
  assign indice = instr[BITS_BUS_DATOS_INSTR +: BITS_REG_INDEX];
  assign dato = instr[BITS_BUS_DATOS_INSTR-1:0];
  assign sel = NUM_TARGETS'(1) << target;
  assign clase = target == '1 ? (indice == BITS_REG_INDEX'(IDX_END) ? CL_END :
                                 indice == BITS_REG_INDEX'(IDX_SYNC) ? CL_SYNC : CL_NOP) :
                 int'(target) < NUM_TARGETS ? CL_WRITE : CL_BAD;
endmodule

// File: rtl/despachador_instrucciones.sv
// despachador_instrucciones: fetches instruction words and dispatches register writes to control blocks
module despachador_instrucciones
  import despachador_pkg::*;
#(
  parameter int BITS_MEMORY_DATA = BITS_MEMORY_DATA_DEF,
  parameter int BITS_ADDR_MEM_ONCHIP = BITS_ADDR_MEM_ONCHIP_DEF,
  parameter int BITS_BUS_DATOS_INSTR = BITS_BUS_DATOS_INSTR_DEF,
  parameter int BITS_TARGET = BITS_TARGET_DEF,
  parameter int NUM_TARGETS = NUM_TARGETS_DEF,
  parameter int MAX_INSTR = MAX_INSTR_DEF
) (
  input logic clk,
  input logic reset,
  input logic iniciar,
  input logic abortar,
  input logic [BITS_ADDR_MEM_ONCHIP-1:0] direccion_inicio,
  despachador_instrucciones_if.master bus,
  output logic ocupado,
  output logic terminado,
  output logic [1:0] codigo_error
);
  localparam int BITS_REG_INDEX = BITS_MEMORY_DATA - BITS_BUS_DATOS_INSTR - BITS_TARGET;
  localparam int CW = $clog2(MAX_INSTR + 1);
  estado_t estado, estado_sig;
  clase_t clase;
  logic [BITS_MEMORY_DATA-1:0] instr;
  logic [CW-1:0] cuenta;
  logic [NUM_TARGETS-1:0] sel;
  logic [BITS_REG_INDEX-1:0] indice;
  logic [BITS_BUS_DATOS_INSTR-1:0] dato;
  logic arranque, captura, limite, libre;

  decodificador_instruccion #(
    .BITS_MEMORY_DATA(BITS_MEMORY_DATA),
    .BITS_BUS_DATOS_INSTR(BITS_BUS_DATOS_INSTR),
    .BITS_TARGET(BITS_TARGET),
    .NUM_TARGETS(NUM_TARGETS)
  ) u_dec (
    .instr(instr),
    .clase(clase),
    .sel(sel),
    .indice(indice),
    .dato(dato)
  );

  assign arranque = estado == S_IDLE && iniciar && !abortar;
  assign captura = estado == S_FETCH && bus.op_complete_mem && !abortar;
  assign limite = cuenta == CW'(MAX_INSTR) && clase != CL_END;
  assign libre = (bus.target_ocupado & sel) == '0;
  assign ocupado = estado != S_IDLE;

  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) estado <= S_IDLE;
    else estado <= estado_sig;

  // next state: an abort that coincides with read completion needs no drain
  always_comb begin
    estado_sig = estado;
    case (estado)
      S_IDLE: estado_sig = arranque ? S_FETCH : S_IDLE;
      S_FETCH: estado_sig = abortar ? (bus.op_complete_mem ? S_IDLE : S_DRAIN) :
                            bus.op_complete_mem ? S_ISSUE : S_FETCH;
      S_ISSUE: estado_sig = abortar || clase == CL_END || limite || clase == CL_BAD ? S_IDLE :
                            clase == CL_SYNC ? S_SYNC :
                            clase == CL_NOP || libre ? S_FETCH : S_ISSUE;
      S_SYNC: estado_sig = abortar ? S_IDLE : bus.target_ocupado == '0 ? S_FETCH : S_SYNC;
      S_DRAIN: estado_sig = bus.op_complete_mem ? S_IDLE : S_DRAIN;
      default: estado_sig = S_IDLE;
    endcase
  end

  // registered memory port, PC, counter, write strobe and status
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bus.read_mem <= 1'b0;
      bus.address_mem <= '0;
      bus.reg_wr_en <= '0;
      bus.reg_addr <= '0;
      bus.reg_data <= '0;
      instr <= '0;
      cuenta <= '0;
      terminado <= 1'b0;
      codigo_error <= ERR_NINGUNO;
    end else begin
      bus.read_mem <= estado_sig == S_FETCH || estado_sig == S_DRAIN;
      bus.reg_wr_en <= '0;
      terminado <= 1'b0;
      if (arranque) begin
        bus.address_mem <= direccion_inicio;
        cuenta <= '0;
        codigo_error <= ERR_NINGUNO;
      end
      if (captura) begin
        instr <= bus.data_mem;
        bus.address_mem <= bus.address_mem + 1'b1;
        cuenta <= cuenta + 1'b1;
      end
      if (estado == S_ISSUE && !abortar) begin
        if (clase == CL_END) terminado <= 1'b1;
        else if (limite) codigo_error <= ERR_LIMITE;
        else if (clase == CL_BAD) codigo_error <= ERR_TARGET;
        else if (clase == CL_WRITE && libre) begin
          bus.reg_wr_en <= sel;
          bus.reg_addr <= indice;
          bus.reg_data <= dato;
        end
      end
    end
endmodule

// File: tb/tb_despachador_instrucciones.sv
// tb_despachador_instrucciones: randomized and directed programs checked against a program-level model
module tb_despachador_instrucciones;
  import despachador_pkg::*;
  localparam int MAXI = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic iniciar = 1'b0;
  logic abortar = 1'b0;
  logic [13:0] direccion_inicio = '0;
  logic ocupado, terminado;
  logic [1:0] codigo_error;
  int n_assert = 0;
  int n_fallos = 0;
  int n_ciclo = 0;
  int t_inicio = 0;
  int n_term = 0;
  int espera_cfg = 0;
  int espera_n = 0;
  logic aleatorio = 1'b0;
  logic [1:0] forzado = '0;
  logic rd_prev = 1'b0;
  logic [13:0] addr_prev = '0;
  logic [1:0] busy_prev = '0;
  logic [31:0] mem [0:16383];
  logic [31:0] prog[$];
  logic [30:0] esp_escr[$], obs_escr[$];
  logic [13:0] esp_dirs[$], obs_dirs[$];
  int t_strobe[$], t_lect[$];
  int esp_term;
  logic [1:0] esp_err;

  despachador_instrucciones_if bus ();

  despachador_instrucciones #(.MAX_INSTR(MAXI)) dut (
    .clk(clk),
    .reset(reset),
    .iniciar(iniciar),
    .abortar(abortar),
    .direccion_inicio(direccion_inicio),
    .bus(bus),
    .ocupado(ocupado),
    .terminado(terminado),
    .codigo_error(codigo_error)
  );

  always #5 clk = ~clk;

  task automatic verificar(input string tag, input logic [63:0] obs, input logic [63:0] esp);
    n_assert++;
    if (obs !== esp) begin
      n_fallos++;
      $display("FAIL %s: obtenido %0h esperado %0h", tag, obs, esp);
    end
  endtask

  task automatic ciclo();
    @(negedge clk);
    n_ciclo++;
    if (rd_prev && bus.read_mem) verificar("addr_estable", 64'(bus.address_mem), 64'(addr_prev));
    if (|bus.reg_wr_en) begin
      obs_escr.push_back({bus.reg_wr_en, bus.reg_addr, bus.reg_data});
      t_strobe.push_back(n_ciclo);
      verificar("strobe_ocupado", 64'(bus.reg_wr_en & busy_prev), 64'(0));
      verificar("strobe_onehot", 64'($onehot(bus.reg_wr_en)), 64'(1));
    end
    if (terminado) n_term++;
    if (!bus.read_mem) begin
      espera_n = 0;
      bus.op_complete_mem = 1'b0;
    end else if (espera_n >= espera_cfg) begin
      bus.op_complete_mem = 1'b1;
      bus.data_mem = mem[bus.address_mem];
      obs_dirs.push_back(bus.address_mem);
      t_lect.push_back(n_ciclo);
    end else begin
      espera_n++;
      bus.op_complete_mem = 1'b0;
    end
    bus.target_ocupado = aleatorio ? 2'($urandom) : forzado;
    rd_prev = bus.read_mem;
    addr_prev = bus.address_mem;
    busy_prev = bus.target_ocupado;
  endtask

  task automatic modelar(input logic [13:0] inicio);
    int cnt;
    logic [2:0] t;
    logic [4:0] x;
    cnt = 0;
    esp_escr.delete();
    esp_dirs.delete();
    esp_err = 2'd0;
    esp_term = 0;
    for (int i = 0; i < prog.size(); i++) begin
      t = prog[i][31:29];
      x = prog[i][28:24];
      esp_dirs.push_back(14'(int'(inicio) + i));
      cnt++;
      if (t == 3'd7 && x == 5'd0) begin esp_term = 1; break; end
      if (cnt == MAXI) begin esp_err = 2'd2; break; end
      if (t >= 3'd2 && t != 3'd7) begin esp_err = 2'd1; break; end
      if (t < 3'd2) esp_escr.push_back({2'(1 << t), x, prog[i][23:0]});
    end
  endtask

  task automatic limpiar();
    obs_escr.delete();
    obs_dirs.delete();
    t_strobe.delete();
    t_lect.delete();
    n_term = 0;
  endtask

  task automatic ejecutar(input string nombre, input logic [13:0] inicio, input int espera,
                          input logic al, input logic [1:0] forz, input int liberar);
    logic fin;
    for (int i = 0; i < prog.size(); i++) mem[14'(int'(inicio) + i)] = prog[i];
    modelar(inicio);
    limpiar();
    espera_cfg = espera;
    aleatorio = al;
    forzado = forz;
    direccion_inicio = inicio;
    iniciar = 1'b1;
    ciclo();
    iniciar = 1'b0;
    t_inicio = n_ciclo;
    fin = 1'b0;
    for (int i = 1; i <= 400 && !fin; i++) begin
      if (i >= liberar) forzado = '0;
      ciclo();
      fin = !ocupado;
    end
    verificar({nombre, "_fin"}, 64'(fin), 64'(1));
    ciclo();
    aleatorio = 1'b0;
    forzado = '0;
    verificar({nombre, "_n_escr"}, 64'(obs_escr.size()), 64'(esp_escr.size()));
    for (int i = 0; i < obs_escr.size() && i < esp_escr.size(); i++)
      verificar({nombre, "_escr"}, 64'(obs_escr[i]), 64'(esp_escr[i]));
    verificar({nombre, "_n_dirs"}, 64'(obs_dirs.size()), 64'(esp_dirs.size()));
    for (int i = 0; i < obs_dirs.size() && i < esp_dirs.size(); i++)
      verificar({nombre, "_dir"}, 64'(obs_dirs[i]), 64'(esp_dirs[i]));
    verificar({nombre, "_term"}, 64'(n_term), 64'(esp_term));
    verificar({nombre, "_err"}, 64'(codigo_error), 64'(esp_err));
  endtask

  function automatic logic [31:0] palabra();
    int r;
    logic [23:0] d;
    logic [4:0] x;
    r = $urandom_range(0, 99);
    d = 24'($urandom);
    x = 5'($urandom);
    if (r < 50) return {3'($urandom_range(0, 1)), x, d};
    if (r < 65) return {3'd7, 5'($urandom_range(2, 31)), d};
    if (r < 75) return {3'd7, 5'd1, d};
    if (r < 80) return {3'($urandom_range(2, 6)), x, d};
    return {3'd7, 5'd0, d};
  endfunction

  task automatic salidas_cero(input string tag);
    verificar({tag, "_read_mem"}, 64'(bus.read_mem), 64'(0));
    verificar({tag, "_address_mem"}, 64'(bus.address_mem), 64'(0));
    verificar({tag, "_reg_wr_en"}, 64'(bus.reg_wr_en), 64'(0));
    verificar({tag, "_reg_addr"}, 64'(bus.reg_addr), 64'(0));
    verificar({tag, "_reg_data"}, 64'(bus.reg_data), 64'(0));
    verificar({tag, "_ocupado"}, 64'(ocupado), 64'(0));
    verificar({tag, "_terminado"}, 64'(terminado), 64'(0));
    verificar({tag, "_codigo_error"}, 64'(codigo_error), 64'(0));
  endtask

  initial begin
    bus.op_complete_mem = 1'b0;
    bus.data_mem = '0;
    bus.target_ocupado = '0;
    ciclo();
    ciclo();
    salidas_cero("reset");
    reset = 1'b1;
    ciclo();

    prog = '{{3'd0, 5'd3, 24'h00ABCD}, {3'd1, 5'd0, 24'h000040}, {3'd7, 5'd0, 24'h0}};
    ejecutar("prog1", 14'h010, 0, 1'b0, 2'b00, 0);
    if (t_strobe.size() == 2) begin
      verificar("prog1_lat", 64'(t_strobe[0] - t_inicio), 64'(2));
      verificar("prog1_ritmo", 64'(t_strobe[1] - t_strobe[0]), 64'(2));
    end

    prog = '{{3'd0, 5'd5, 24'h123456}, {3'd7, 5'd0, 24'h0}};
    ejecutar("ocup", 14'h040, 0, 1'b0, 2'b01, 6);
    if (t_strobe.size() == 1) verificar("ocup_ciclo", 64'(t_strobe[0] - t_inicio), 64'(7));

    prog = '{{3'd7, 5'd1, 24'h0}, {3'd1, 5'd2, 24'h0000AA}, {3'd7, 5'd0, 24'h0}};
    ejecutar("sync", 14'h050, 0, 1'b0, 2'b11, 6);
    if (t_lect.size() >= 2) verificar("sync_ciclo", 64'(t_lect[1] - t_inicio), 64'(7));

    prog = '{{3'd3, 5'd4, 24'h555555}, {3'd7, 5'd0, 24'h0}};
    ejecutar("malo", 14'h060, 1, 1'b0, 2'b00, 0);
    verificar("malo_ocupado", 64'(ocupado), 64'(0));

    prog.delete();
    for (int i = 0; i < 10; i++) prog.push_back({3'd7, 5'd5, 24'($urandom)});
    ejecutar("nop_wrap", 14'h3FFE, 0, 1'b0, 2'b00, 0);

    prog = '{{3'd0, 5'd7, 24'hBEEF01}};
    mem[14'h020] = prog[0];
    limpiar();
    espera_cfg = 3;
    direccion_inicio = 14'h020;
    iniciar = 1'b1;
    ciclo();
    iniciar = 1'b0;
    abortar = 1'b1;
    ciclo();
    abortar = 1'b0;
    for (int i = 3; i <= 5; i++) begin
      ciclo();
      verificar("abort_read_mem", 64'(bus.read_mem), 64'(i <= 4));
    end
    ciclo();
    ciclo();
    verificar("abort_ocupado", 64'(ocupado), 64'(0));
    verificar("abort_escr", 64'(obs_escr.size()), 64'(0));
    verificar("abort_lect", 64'(obs_dirs.size()), 64'(1));
    verificar("abort_term", 64'(n_term), 64'(0));
    verificar("abort_err", 64'(codigo_error), 64'(0));
    espera_cfg = 0;

    iniciar = 1'b1;
    abortar = 1'b1;
    ciclo();
    iniciar = 1'b0;
    abortar = 1'b0;
    ciclo();
    verificar("abort_inicio_ocupado", 64'(ocupado), 64'(0));
    verificar("abort_inicio_read", 64'(bus.read_mem), 64'(0));

    prog = '{{3'd0, 5'd9, 24'h777777}, {3'd7, 5'd0, 24'h0}};
    mem[14'h100] = prog[0];
    mem[14'h101] = prog[1];
    forzado = 2'b01;
    direccion_inicio = 14'h100;
    iniciar = 1'b1;
    ciclo();
    iniciar = 1'b0;
    for (int i = 0; i < 4; i++) ciclo();
    verificar("pre_reset_ocupado", 64'(ocupado), 64'(1));
    verificar("pre_reset_addr", 64'(bus.address_mem), 64'(14'h101));
    #2 reset = 1'b0;
    #1 salidas_cero("reset_async");
    reset = 1'b1;
    forzado = '0;
    ciclo();
    ciclo();

    for (int r = 0; r < 25; r++) begin
      prog.delete();
      for (int j = 0; j < 10; j++) prog.push_back(palabra());
      ejecutar("aleat", 14'($urandom), $urandom_range(0, 2), 1'b1, 2'b00, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fallos);
    $finish;
  end
endmodule
